// File: rtl/alu_op_sequencer.sv
// ALU control decode plus iterative mult/div engine with HI/LO; mult/div finish WIDTH+1 edges after start.
// No backpressure: start is dropped unless IDLE with a sequenced op; busy holds the EX state.
module alu_op_sequencer #(
   parameter int WIDTH    = 32,
   parameter int CTRLSIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          Operation,
   input  logic [5:0]          funct,
   input  logic                start,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic [CTRLSIZE-1:0] ControlSignal,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    hi,
   output logic [WIDTH-1:0]    lo
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, hi_q, lo_q;
   logic               neg_q, rneg_q, div_q, busy_q, done_q;

   always_comb begin
      ControlSignal = '0;
      case (Operation)
         3'b000:  ControlSignal = CTRLSIZE'(4'b0000);
         3'b001:  ControlSignal = CTRLSIZE'(4'b0001);
         3'b011:  ControlSignal = CTRLSIZE'(4'b0000);
         3'b100:  ControlSignal = CTRLSIZE'(4'b1000);
         3'b101:  ControlSignal = CTRLSIZE'(4'b1001);
         3'b110:  ControlSignal = CTRLSIZE'(4'b1100);
         3'b111:  ControlSignal = CTRLSIZE'(4'b1101);
         default: begin
            case (funct)
               6'b100000: ControlSignal = CTRLSIZE'(4'b0000);
               6'b100010: ControlSignal = CTRLSIZE'(4'b0001);
               6'b100100: ControlSignal = CTRLSIZE'(4'b1000);
               6'b100101: ControlSignal = CTRLSIZE'(4'b1001);
               6'b100110: ControlSignal = CTRLSIZE'(4'b1100);
               6'b100111: ControlSignal = CTRLSIZE'(4'b1011);
               6'b101010: ControlSignal = CTRLSIZE'(4'b1101);
               default:   ControlSignal = CTRLSIZE'(4'b0000);
            endcase
         end
      endcase
   end

   logic             is_mul, is_div, signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
   assign signed_op = (funct == F_MULT) || (funct == F_DIV);
   assign a_neg     = signed_op & a[WIDTH-1];
   assign b_neg     = signed_op & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

   // Shift-add works on {acc,q} shifting right; restoring divide shifts left.
   logic [WIDTH:0]   mul_sum, mul_sel, div_tmp;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   always_comb begin
      mul_sum  = {1'b0, acc_q} + {1'b0, m_q};
      mul_sel  = q_q[0] ? mul_sum : {1'b0, acc_q};
      div_tmp  = {acc_q, q_q[WIDTH-1]};
      div_ge   = (div_tmp >= {1'b0, m_q});
      div_diff = div_tmp[WIDTH-1:0] - m_q;
      acc_d    = acc_q;
      q_d      = q_q;
      if (state_q == MUL) begin
         acc_d = mul_sel[WIDTH:1];
         q_d   = {mul_sel[0], q_q[WIDTH-1:1]};
      end else if (state_q == DIV) begin
         acc_d = div_ge ? div_diff : div_tmp[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], div_ge};
      end
   end

   logic [2*WIDTH-1:0] prod, prod_r;
   logic [WIDTH-1:0]   quo_r, rem_r;

   assign prod   = {acc_q, q_q};
   assign prod_r = neg_q ? -prod : prod;
   assign quo_r  = neg_q ? -q_q : q_q;
   assign rem_r  = rneg_q ? -acc_q : acc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         m_q     <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && Operation == 3'b010) begin
                  if (funct == F_MTHI) begin
                     hi_q <= a;
                  end else if (funct == F_MTLO) begin
                     lo_q <= a;
                  end else if (is_mul || is_div) begin
                     cnt_q  <= '0;
                     m_q    <= b_mag;
                     busy_q <= 1'b1;
                     div_q  <= is_div;
                     // Divide by zero preloads the FIX registers so FIX emits hi=a, lo=all-ones.
                     if (is_div && b == '0) begin
                        acc_q   <= a;
                        q_q     <= '1;
                        neg_q   <= 1'b0;
                        rneg_q  <= 1'b0;
                        state_q <= FIX;
                     end else begin
                        acc_q   <= '0;
                        q_q     <= a_mag;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        state_q <= is_div ? DIV : MUL;
                     end
                  end
               end
            end
            MUL, DIV: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) state_q <= FIX;
            end
            FIX: begin
               if (div_q) begin
                  hi_q <= rem_r;
                  lo_q <= quo_r;
               end else begin
                  hi_q <= prod_r[2*WIDTH-1:WIDTH];
                  lo_q <= prod_r[WIDTH-1:0];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; mult/div results checked by a done-driven scoreboard monitor.
module tb_alu_op_sequencer;
   localparam int W = 32;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_ADD   = 6'b100000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   Operation = '0;
   logic [5:0]   funct = '0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   ControlSignal;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   alu_op_sequencer #(.WIDTH(W), .CTRLSIZE(4)) dut (
      .clk(clk), .rst(rst), .Operation(Operation), .funct(funct), .start(start),
      .a(a), .b(b), .ControlSignal(ControlSignal), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected {hi,lo}.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_unexpected: got done=1 expected no pending result");
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_hi", {32'h0, hi}, {32'h0, mon_e[63:32]});
            chk("result_lo", {32'h0, lo}, {32'h0, mon_e[31:0]});
         end
      end
   end

   task automatic dec(input string name, input logic [2:0] op, input logic [5:0] f, input logic [3:0] exp);
      Operation = op;
      funct     = f;
      #1;
      chk(name, {60'h0, ControlSignal}, {60'h0, exp});
   endtask

   task automatic run_seq(input string name, input logic [5:0] f, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [63:0] exp, input int exp_lat,
                          input bit intrude);
      int cyc;
      int busy_n;
      bit got;
      exp_q.push_back(exp);
      @(negedge clk);
      Operation = 3'b010;
      funct     = f;
      a         = av;
      b         = bv;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      busy_n = int'(busy);
      cyc    = 0;
      got    = 1'b0;
      while (cyc < 100 && !got) begin
         if (intrude && cyc == 4) begin
            funct = F_MULT;
            a     = 32'h0000_0009;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (intrude && cyc == 5) start = 1'b0;
         if (done) got = 1'b1;
         else busy_n += int'(busy);
      end
      chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
      chk({name, "_busy_at_done"}, {63'h0, busy}, 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("reset_busy", {63'h0, busy}, 64'h0);
      chk("reset_done", {63'h0, done}, 64'h0);
      chk("reset_hi", {32'h0, hi}, 64'h0);
      chk("reset_lo", {32'h0, lo}, 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      dec("dec_slt",   3'b010, 6'b101010, 4'b1101);
      dec("dec_nor",   3'b010, 6'b100111, 4'b1011);
      dec("dec_mult",  3'b010, 6'b011000, 4'b0000);
      dec("dec_sub",   3'b010, 6'b100010, 4'b0001);
      dec("dec_op111", 3'b111, 6'b000000, 4'b1101);
      dec("dec_op001", 3'b001, 6'b101010, 4'b0001);
      dec("dec_op100", 3'b100, 6'b000000, 4'b1000);

      run_seq("multu", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 33, 1'b0);
      run_seq("mult",  F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 33, 1'b0);
      run_seq("div",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
      run_seq("divmin", F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1'b0);
      run_seq("divu0", F_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF, 1, 1'b0);

      @(negedge clk);
      funct = F_MTLO;
      a     = 32'h0000_ABCD;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("mtlo_lo", {32'h0, lo}, 64'h0000_ABCD);
      chk("mtlo_hi_hold", {32'h0, hi}, 64'h1234_5678);
      chk("mtlo_busy", {63'h0, busy}, 64'h0);
      @(posedge clk);
      #1;
      chk("mtlo_no_done", {63'h0, done}, 64'h0);

      @(negedge clk);
      funct = F_ADD;
      a     = 32'hDEAD_BEEF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("alu_hold_lo", {32'h0, lo}, 64'h0000_ABCD);
      chk("alu_hold_busy", {63'h0, busy}, 64'h0);

      run_seq("divu_ign", F_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 1'b1);

      @(negedge clk);
      Operation = 3'b010;
      funct     = F_MULT;
      a         = 32'hFFFF_FFFD;
      b         = 32'h0000_0005;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", {63'h0, busy}, 64'h0);
      chk("rst_mid_done", {63'h0, done}, 64'h0);
      chk("rst_mid_hi", {32'h0, hi}, 64'h0);
      chk("rst_mid_lo", {32'h0, lo}, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      run_seq("multu_post", F_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 33, 1'b0);

      repeat (40) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      chk("idle_busy", {63'h0, busy}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
